seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// state | meaning: IDLE wait for start | CALC eight restoring steps | DONE one-cycle result pulse
module seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] dq_q, dq_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] dvs_q, dvs_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quotient_q, quotient_d;
    logic [3:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic [4:0] rem5;
    logic [4:0] rem_sub;
    logic [7:0] dq_shift;
    logic       fits;

    always_comb begin
        rem5     = {rem_q, dq_q[7]};
        dq_shift = {dq_q[6:0], 1'b0};
        fits     = (rem5 >= {1'b0, dvs_q});
        rem_sub  = rem5 - {1'b0, dvs_q};

        state_d     = state_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dq_d  = dividend;
                    dvs_d = divisor;
                    rem_d = 4'd0;
                    cnt_d = 3'd0;
                    if (divisor == 4'd0) begin
                        quotient_d  = 8'hFF;
                        remainder_d = dividend[3:0];
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Partial remainder stays below the divisor, so 4 bits always suffice.
                if (fits) begin
                    rem_d = rem_sub[3:0];
                    dq_d  = dq_shift | 8'd1;
                end else begin
                    rem_d = rem5[3:0];
                    dq_d  = dq_shift;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quotient_d  = dq_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dq_q        <= 8'd0;
            rem_q       <= 4'd0;
            dvs_q       <= 4'd0;
            cnt_q       <= 3'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 4'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_CALC);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
